// File: rtl/calc_if.sv
// calc_if: key-token and result bus between the keypad front end and calc_engine.
//   key_valid    one-cycle strobe, key_code holds a new token
//   key_code     4-bit token: 0-9 digit, 10 plus, 11 minus, 12 mult, 13 div, 14 enter
//   busy         high while a division runs; keys are dropped while high
//   result       W-bit two's complement result
//   result_valid level, result/error are final for the current operation
//   error        level, overflow or divide-by-zero in the current operation
// master drives keys (front end / testbench), slave is the calculator core.
interface calc_if #(
  parameter int W = 11
);
  logic         key_valid;
  logic [3:0]   key_code;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         error;

  modport master (
    output key_valid, key_code,
    input  busy, result, result_valid, error
  );

  modport slave (
    input  key_valid, key_code,
    output busy, result, result_valid, error
  );
endinterface

// File: rtl/calc_engine.sv
// calc_engine: signed integer calculator core for the keypad front end.
// Builds two signed decimal operands from key tokens, then performs add, sub,
// mult (single cycle) or div (restoring divider, one quotient bit per cycle).
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset, wins over everything
//   bus  calc_if.slave: key tokens in; busy, result, result_valid, error out
module calc_engine #(
  parameter int W      = 11,
  parameter int DIGITS = 3
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);

  localparam int AW  = W + 4;
  localparam int PW  = 2 * (AW + 1);
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int DCW = $clog2(W + 1);

  localparam logic [3:0] K_PLUS  = 4'd10;
  localparam logic [3:0] K_MINUS = 4'd11;
  localparam logic [3:0] K_ENTER = 4'd14;

  // Largest operand magnitude and result bounds in the wide arithmetic domain
  localparam logic [AW-1:0]        OMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] RMAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] RMIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {SIGN1, OP1, OPER, SIGN2, OP2, EXEC, DIV, DONE} state_e;
  // Encoding matches key_code[1:0] of the operator keys 10..13
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_e;

  state_e          state;
  op_e             op;
  logic [AW-1:0]   acc1, acc2;
  logic [CW-1:0]   cnt1, cnt2;
  logic            sign1, sign2, ovf;
  logic [W-1:0]    rem, quo, divisor;
  logic            neg;
  logic [DCW-1:0]  div_cnt;
  logic [W-1:0]    result;
  logic            result_valid, error, busy;

  logic            accept, is_digit, is_oper;
  logic [AW-1:0]   key_ext, grow1, grow2;
  logic signed [AW:0]   a_val, b_val;
  logic signed [PW-1:0] a_ext, b_ext, value;
  logic            in_range;
  logic [W:0]      trial;

  assign bus.result       = result;
  assign bus.result_valid = result_valid;
  assign bus.error        = error;
  assign bus.busy         = busy;

  // Key decode, digit accumulation (acc*10 + d as shifts), signed operands,
  // wide-precision exec value with range check, and the divider trial subtract.
  always_comb begin
    accept   = bus.key_valid && !busy;
    is_digit = bus.key_code < 4'd10;
    is_oper  = (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
    key_ext  = {{(AW-4){1'b0}}, bus.key_code};
    grow1    = (acc1 << 3) + (acc1 << 1) + key_ext;
    grow2    = (acc2 << 3) + (acc2 << 1) + key_ext;
    a_val    = sign1 ? -{1'b0, acc1} : {1'b0, acc1};
    b_val    = sign2 ? -{1'b0, acc2} : {1'b0, acc2};
    a_ext    = {{(PW-AW-1){a_val[AW]}}, a_val};
    b_ext    = {{(PW-AW-1){b_val[AW]}}, b_val};
    value    = '0;
    case (op)
      OP_ADD:  value = a_ext + b_ext;
      OP_SUB:  value = a_ext - b_ext;
      OP_MUL:  value = a_ext * b_ext;
      default: value = '0;
    endcase
    in_range = (value >= RMIN) && (value <= RMAX);
    trial    = {rem, quo[W-1]} - {1'b0, divisor};
  end

  // Main FSM. DONE first clears the finished operation, then falls into the
  // SIGN1 handling below so a digit or sign immediately starts a new one
  // (the later non-blocking assignments override the clears).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SIGN1;
      op           <= OP_MUL;
      acc1         <= '0;
      acc2         <= '0;
      cnt1         <= '0;
      cnt2         <= '0;
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      ovf          <= 1'b0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      neg          <= 1'b0;
      div_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (state == DONE && accept) begin
        result_valid <= 1'b0;
        error        <= 1'b0;
        op           <= OP_MUL;
        acc1         <= '0;
        acc2         <= '0;
        cnt1         <= '0;
        cnt2         <= '0;
        sign1        <= 1'b0;
        sign2        <= 1'b0;
        ovf          <= 1'b0;
        state        <= SIGN1;
      end
      case (state)
        SIGN1, DONE: begin
          if (accept) begin
            if (bus.key_code == K_PLUS) begin
              sign1 <= 1'b0;
              state <= OP1;
            end else if (bus.key_code == K_MINUS) begin
              sign1 <= 1'b1;
              state <= OP1;
            end else if (is_digit) begin
              sign1 <= 1'b0;
              acc1  <= key_ext;
              cnt1  <= CW'(1);
              if (key_ext > OMAX) ovf <= 1'b1;
              state <= OP1;
            end
          end
        end
        OP1: begin
          if (accept) begin
            if (is_digit) begin
              if (cnt1 < CW'(DIGITS)) begin
                acc1 <= grow1;
                cnt1 <= cnt1 + 1'b1;
                if (grow1 > OMAX) ovf <= 1'b1;
              end
            end else if (bus.key_code == K_ENTER) begin
              state <= OPER;
            end else if (is_oper) begin
              op    <= op_e'(bus.key_code[1:0]);
              state <= SIGN2;
            end
          end
        end
        OPER: begin
          if (accept && is_oper) begin
            op    <= op_e'(bus.key_code[1:0]);
            state <= SIGN2;
          end
        end
        SIGN2: begin
          if (accept) begin
            if (bus.key_code == K_PLUS) begin
              sign2 <= 1'b0;
              state <= OP2;
            end else if (bus.key_code == K_MINUS) begin
              sign2 <= 1'b1;
              state <= OP2;
            end else if (is_digit) begin
              sign2 <= 1'b0;
              acc2  <= key_ext;
              cnt2  <= CW'(1);
              if (key_ext > OMAX) ovf <= 1'b1;
              state <= OP2;
            end
          end
        end
        OP2: begin
          if (accept) begin
            if (is_digit) begin
              if (cnt2 < CW'(DIGITS)) begin
                acc2 <= grow2;
                cnt2 <= cnt2 + 1'b1;
                if (grow2 > OMAX) ovf <= 1'b1;
              end
            end else if (bus.key_code == K_ENTER) begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          // Operand magnitudes are the accumulators themselves; with no
          // operand overflow they fit in W bits for the divider.
          if (ovf) begin
            error        <= 1'b1;
            result       <= '0;
            result_valid <= 1'b1;
            state        <= DONE;
          end else if (op == OP_DIV) begin
            if (acc2 == '0) begin
              error        <= 1'b1;
              result       <= '0;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              rem     <= '0;
              quo     <= acc1[W-1:0];
              divisor <= acc2[W-1:0];
              neg     <= sign1 ^ sign2;
              div_cnt <= '0;
              busy    <= 1'b1;
              state   <= DIV;
            end
          end else begin
            if (in_range) begin
              result <= value[W-1:0];
              error  <= 1'b0;
            end else begin
              result <= '0;
              error  <= 1'b1;
            end
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DIV: begin
          // W shift/subtract steps, then one cycle to apply the sign
          if (div_cnt == DCW'(W)) begin
            result       <= neg ? -quo : quo;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            if (!trial[W]) begin
              rem <= trial[W-1:0];
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= {rem[W-2:0], quo[W-1]};
              quo <= {quo[W-2:0], 1'b0};
            end
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= SIGN1;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: scoreboard bench for calc_engine (W=11, DIGITS=3).
// Stimulus pushes the hand-computed result/error before sending enter; a
// monitor pops and compares on every rising edge of result_valid.
module tb_calc_engine;
  localparam int W = 11;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  calc_if #(.W(W)) bus ();

  calc_engine #(.W(W), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One key per cycle; returns #1 after the accepting edge
  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic sendKeys(input int keys[$]);
    foreach (keys[i]) applyStimulus(4'(keys[i]));
  endtask

  task automatic expectResult(input logic [W-1:0] res, input logic err, input string name);
    exp_t e;
    e.res  = res;
    e.err  = err;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Bounded wait for result_valid, then give the monitor its negedge
  task automatic waitResult(input string name);
    int n = 0;
    while (!bus.result_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.result_valid) checkOutput({name, " timeout"}, 0, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare each new result against the scoreboard head
  always @(negedge clk) begin
    if (bus.result_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput({e.name, " result"}, int'(bus.result), int'(e.res));
        checkOutput({e.name, " error"}, int'(bus.error), int'(e.err));
      end
    end
    prev_valid <= bus.result_valid;
  end

  initial begin
    int busy_cnt;
    int first_valid;
    int busy_seen;

    bus.key_valid = 1'b0;
    bus.key_code  = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset result_valid", int'(bus.result_valid), 0);
    checkOutput("reset error", int'(bus.error), 0);
    checkOutput("reset result", int'(bus.result), 0);
    @(negedge clk);
    rst = 1'b0;

    // 12 + 34 via enter then operator key; valid one cycle after enter
    sendKeys('{1, 2, 14, 10, 3, 4});
    expectResult(11'd46, 1'b0, "add 12+34");
    applyStimulus(4'd14);
    checkOutput("add valid before", int'(bus.result_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("add valid latency", int'(bus.result_valid), 1);
    waitResult("add");

    // -5 * 7 with operator shortcut, started from DONE
    sendKeys('{11, 5, 12, 7});
    expectResult(11'h7DD, 1'b0, "mult -5*7");
    applyStimulus(4'd14);
    @(posedge clk);
    #1;
    checkOutput("mult valid latency", int'(bus.result_valid), 1);
    waitResult("mult");

    // 100 / 7 with junk keys thrown in while busy
    sendKeys('{1, 0, 0, 13, 7});
    expectResult(11'd14, 1'b0, "div 100/7");
    applyStimulus(4'd14);
    busy_cnt    = 0;
    first_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) begin
        first_valid = i;
        bus.key_valid = 1'b0;
        break;
      end
      if (bus.busy) begin
        busy_cnt++;
        bus.key_valid = 1'b1;
        bus.key_code  = (i % 2 == 0) ? 4'd14 : 4'd9;
      end else begin
        bus.key_valid = 1'b0;
      end
    end
    bus.key_valid = 1'b0;
    checkOutput("div busy cycles", busy_cnt, W + 1);
    checkOutput("div valid latency", first_valid, W + 2);
    waitResult("div");

    // -9 / 2 truncates toward zero
    sendKeys('{11, 9, 13, 2});
    expectResult(11'h7FC, 1'b0, "div -9/2");
    applyStimulus(4'd14);
    waitResult("div neg");

    // divide by zero: error, no busy
    sendKeys('{9, 13, 0});
    expectResult(11'd0, 1'b1, "div by zero");
    applyStimulus(4'd14);
    busy_seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (bus.busy) busy_seen = 1;
      @(posedge clk);
      #1;
    end
    checkOutput("div0 busy never", busy_seen, 0);
    waitResult("div0");

    // 999 * 999 overflows
    sendKeys('{9, 9, 9, 12, 9, 9, 9});
    expectResult(11'd0, 1'b1, "mult overflow");
    applyStimulus(4'd14);
    waitResult("ovf");

    // fourth digit ignored: 123 + 0
    sendKeys('{1, 2, 3, 4, 14, 10, 0});
    expectResult(11'd123, 1'b0, "digit limit");
    applyStimulus(4'd14);
    waitResult("digits");

    // reset in the middle of a division
    sendKeys('{1, 0, 0, 13, 7, 14});
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("div running before rst", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst busy", int'(bus.busy), 0);
    checkOutput("rst result_valid", int'(bus.result_valid), 0);
    checkOutput("rst error", int'(bus.error), 0);
    @(negedge clk);
    rst = 1'b0;
    sendKeys('{2, 10, 2});
    expectResult(11'd4, 1'b0, "after rst 2+2");
    applyStimulus(4'd14);
    waitResult("post rst");

    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
